// File: rtl/vm_change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin-select encoding and coin values.
package vm_change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_C5   = 2'd1,
    SEL_C2   = 2'd2,
    SEL_C1   = 2'd3
  } coin_sel_t;

  localparam logic [7:0] COIN5_VAL = 8'd5;
  localparam logic [7:0] COIN2_VAL = 8'd2;
  localparam logic [7:0] COIN1_VAL = 8'd1;

  function automatic logic [7:0] coin_value(input coin_sel_t sel);
    case (sel)
      SEL_C5:  coin_value = COIN5_VAL;
      SEL_C2:  coin_value = COIN2_VAL;
      SEL_C1:  coin_value = COIN1_VAL;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_timer.sv
// Loadable down-counter with zero flag; times both the solenoid pulse and
// the mechanical gap that follows it.
module change_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout (5, 2, 1), one timed solenoid pulse plus gap per coin.
// Optional coin-tube stock tracking is enabled by defining TUBE_LIMIT_EN.
module change_dispenser
  import vm_change_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
`ifdef TUBE_LIMIT_EN
  parameter int TUBE5_INIT   = 10,
  parameter int TUBE2_INIT   = 10,
`endif
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       coin5_out,
  output logic       coin2_out,
  output logic       coin1_out,
  output logic [7:0] remaining,
  output logic [7:0] coin_count,
`ifdef TUBE_LIMIT_EN
  input  logic       tube_refill,
  output logic       tube5_empty,
  output logic       tube2_empty,
`endif
  output logic [2:0] state_dbg
);

  state_t     state, next_state;
  coin_sel_t  coin_sel, sel_next;
  logic [7:0] remaining_q, coin_count_q;
  logic       busy_q, aborted_q;
  logic       tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic       can5, can2, pay_now, cancel;

  change_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign cancel  = abort && (state != ST_IDLE);
  assign pay_now = (state == ST_PULSE) && tmr_zero && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      ST_IDLE:   if (start) next_state = (amount == 8'd0) ? ST_DONE : ST_SELECT;
      ST_SELECT: begin
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(PULSE_CYCLES - 1);
        next_state = ST_PULSE;
      end
      ST_PULSE: if (tmr_zero) begin
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(GAP_CYCLES - 1);
        next_state = ST_GAP;
      end
      ST_GAP:    if (tmr_zero) next_state = (remaining_q == 8'd0) ? ST_DONE : ST_SELECT;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    if (cancel) next_state = ST_IDLE;
  end

  // Greedy pick, skipping a denomination whose tube has run out
  always_comb begin
    sel_next = SEL_C1;
    if (remaining_q >= COIN5_VAL && can5)      sel_next = SEL_C5;
    else if (remaining_q >= COIN2_VAL && can2) sel_next = SEL_C2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_q  <= 8'd0;
      coin_count_q <= 8'd0;
      coin_sel     <= SEL_NONE;
      busy_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      aborted_q <= cancel;
      if (state == ST_IDLE && start) begin
        remaining_q  <= amount;
        coin_count_q <= 8'd0;
        busy_q       <= (amount != 8'd0);
      end else if (state == ST_DONE || cancel) begin
        busy_q <= 1'b0;
      end
      if (state == ST_SELECT && !abort) coin_sel <= sel_next;
      if (pay_now) begin
        remaining_q  <= remaining_q - coin_value(coin_sel);
        coin_count_q <= (coin_count_q == 8'hFF) ? 8'hFF : coin_count_q + 8'd1;
      end
    end
  end

`ifdef TUBE_LIMIT_EN
  logic [7:0] tube5_q, tube2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tube5_q <= 8'(TUBE5_INIT);
      tube2_q <= 8'(TUBE2_INIT);
    end else if (tube_refill && !busy_q) begin
      tube5_q <= 8'(TUBE5_INIT);
      tube2_q <= 8'(TUBE2_INIT);
    end else if (pay_now) begin
      if (coin_sel == SEL_C5 && tube5_q != 8'd0) tube5_q <= tube5_q - 8'd1;
      if (coin_sel == SEL_C2 && tube2_q != 8'd0) tube2_q <= tube2_q - 8'd1;
    end
  end

  assign tube5_empty = (tube5_q == 8'd0);
  assign tube2_empty = (tube2_q == 8'd0);
  assign can5        = !tube5_empty;
  assign can2        = !tube2_empty;
`else
  assign can5 = 1'b1;
  assign can2 = 1'b1;
`endif

  // Coin drives decode registered state only, so reset cuts them at once
  assign coin5_out  = (state == ST_PULSE) && (coin_sel == SEL_C5);
  assign coin2_out  = (state == ST_PULSE) && (coin_sel == SEL_C2);
  assign coin1_out  = (state == ST_PULSE) && (coin_sel == SEL_C1);
  assign done       = (state == ST_DONE);
  assign busy       = busy_q;
  assign aborted    = aborted_q;
  assign remaining  = remaining_q;
  assign coin_count = coin_count_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser; tube checks are built in when
// TUBE_LIMIT_EN is defined.
module tb_change_dispenser;
  import vm_change_pkg::*;

  localparam int P = 2;
  localparam int G = 3;
`ifdef TUBE_LIMIT_EN
  localparam int T5_INIT = 1;
  localparam int T2_INIT = 10;
`endif

  logic       clk, rst, start, abort;
  logic [7:0] amount;
  logic       busy, done, aborted, coin5_out, coin2_out, coin1_out;
  logic [7:0] remaining, coin_count;
  logic [2:0] state_dbg;
`ifdef TUBE_LIMIT_EN
  logic       tube_refill, tube5_empty, tube2_empty;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: tube stock and expected per-cycle trace
  // trace word = {coin5, coin2, coin1, remaining[7:0], done, busy}
  int          m_t5, m_t2, exp_count;
  logic [7:0]  exp_q[$];
  logic [12:0] exp_trace_q[$];
  logic [12:0] act_trace_q[$];
  logic        act_abt_q[$];
  logic [2:0]  act_state_q[$];

  change_dispenser #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
`ifdef TUBE_LIMIT_EN
    .TUBE5_INIT   (T5_INIT),
    .TUBE2_INIT   (T2_INIT),
`endif
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amount     (amount),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .coin5_out  (coin5_out),
    .coin2_out  (coin2_out),
    .coin1_out  (coin1_out),
    .remaining  (remaining),
    .coin_count (coin_count),
`ifdef TUBE_LIMIT_EN
    .tube_refill(tube_refill),
    .tube5_empty(tube5_empty),
    .tube2_empty(tube2_empty),
`endif
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
`ifdef TUBE_LIMIT_EN
    m_t5 = T5_INIT;
    m_t2 = T2_INIT;
`else
    m_t5 = 1 << 30;
    m_t2 = 1 << 30;
`endif
  endtask

  // Greedy payout from plain arithmetic; each coin is select, P pulse, G gap
  task automatic model_payout(input int amt);
    int rem;
    logic [2:0] code;
    logic bz;
    exp_q.delete();
    exp_trace_q.delete();
    rem = amt;
    bz  = (amt != 0);
    while (rem > 0) begin
      int c;
      if (rem >= 5 && m_t5 > 0) begin c = 5; m_t5--; end
      else if (rem >= 2 && m_t2 > 0) begin c = 2; m_t2--; end
      else c = 1;
      exp_q.push_back(8'(c));
      code = (c == 5) ? 3'b100 : (c == 2) ? 3'b010 : 3'b001;
      exp_trace_q.push_back({3'b000, 8'(rem), 1'b0, 1'b1});
      for (int i = 0; i < P; i++) exp_trace_q.push_back({code, 8'(rem), 1'b0, 1'b1});
      rem -= c;
      for (int i = 0; i < G; i++) exp_trace_q.push_back({3'b000, 8'(rem), 1'b0, 1'b1});
    end
    exp_trace_q.push_back({3'b000, 8'd0, 1'b1, bz});
    exp_trace_q.push_back({3'b000, 8'd0, 1'b0, 1'b0});
    exp_count = (exp_q.size() > 255) ? 255 : exp_q.size();
  endtask

  // Pulses start, then samples n cycles; ev_kind 1 = second start, 2 = abort
  // at cycle ev_at, 3 = abort alongside the initial start
  task automatic run_cycles(input int amt, input int n, input int ev_at,
                            input int ev_kind, input int amt2);
    act_trace_q.delete();
    act_abt_q.delete();
    act_state_q.delete();
    start  = 1'b1;
    amount = amt[7:0];
    abort  = (ev_kind == 3);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= n; k++) begin
      act_trace_q.push_back({coin5_out, coin2_out, coin1_out, remaining, done, busy});
      act_abt_q.push_back(aborted);
      act_state_q.push_back(state_dbg);
      if (k == ev_at) begin
        if (ev_kind == 1) begin start = 1'b1; amount = amt2[7:0]; end
        else if (ev_kind == 2) abort = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; amount = 8'd0;
`ifdef TUBE_LIMIT_EN
    tube_refill = 1'b0;
`endif
    model_reset();
    #13;
    checks++;
    if ({busy, done, aborted, coin5_out, coin2_out, coin1_out, remaining, coin_count} !== 22'd0
        || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b abt=%b coins=%b rem=%0d cnt=%0d st=%0d, expected all zero/IDLE",
               busy, done, aborted, {coin5_out, coin2_out, coin1_out}, remaining, coin_count, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_payout_8();
    model_payout(8);
    run_cycles(8, exp_trace_q.size(), 0, 0, 0);
    for (int k = 0; k < exp_trace_q.size(); k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL payout8 cycle %0d: got coin/rem/done/busy=%h expected %h", k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
    checks++;
    if (coin_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL payout8_count: got %0d expected %0d", coin_count, exp_count);
    end
  endtask

  task automatic test_zero_amount();
    model_payout(0);
    run_cycles(0, exp_trace_q.size(), 0, 0, 0);
    for (int k = 0; k < exp_trace_q.size(); k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL zero_amount cycle %0d: got %h expected %h", k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
  endtask

  task automatic test_abort();
    int sv5, sv2;
    logic [7:0] rem_left;
    sv5 = m_t5;
    sv2 = m_t2;
    model_payout(12);
    m_t5 = sv5 - ((exp_q[0] == 8'd5) ? 1 : 0);
    m_t2 = sv2 - ((exp_q[0] == 8'd2) ? 1 : 0);
    rem_left = 8'd12 - exp_q[0];
    run_cycles(12, 10, P + G + 3, 2, 0);
    for (int k = 0; k < P + G + 3; k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
    checks++;
    if (act_trace_q[P + G + 3] !== {3'b000, rem_left, 1'b0, 1'b0} || act_abt_q[P + G + 3] !== 1'b1
        || act_state_q[P + G + 3] !== ST_IDLE) begin
      errors++;
      $display("FAIL abort_cut: got %h abt=%b st=%0d expected %h abt=1 st=IDLE",
               act_trace_q[P + G + 3], act_abt_q[P + G + 3], act_state_q[P + G + 3], {3'b000, rem_left, 2'b00});
    end
    checks++;
    if (act_abt_q[P + G + 4] !== 1'b0 || remaining !== rem_left || coin_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_after: got abt=%b rem=%0d cnt=%0d expected abt=0 rem=%0d cnt=1",
               act_abt_q[P + G + 4], remaining, coin_count, rem_left);
    end
  endtask

  task automatic test_ignore_start();
    model_payout(4);
    run_cycles(4, exp_trace_q.size(), 3, 1, 9);
    for (int k = 0; k < exp_trace_q.size(); k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL ignore_start cycle %0d: got %h expected %h", k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
    checks++;
    if (coin_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL ignore_start_count: got %0d expected %0d", coin_count, exp_count);
    end
  endtask

  task automatic test_start_abort_idle();
    int amt;
    amt = $urandom_range(1, 20);
    model_payout(amt);
    run_cycles(amt, exp_trace_q.size(), 0, 3, 0);
    for (int k = 0; k < exp_trace_q.size(); k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL start_abort_idle amt=%0d cycle %0d: got %h expected %h", amt, k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int amt;
      amt = $urandom_range(0, 40);
      model_payout(amt);
      run_cycles(amt, exp_trace_q.size(), 0, 0, 0);
      for (int k = 0; k < exp_trace_q.size(); k++) begin
        checks++;
        if (act_trace_q[k] !== exp_trace_q[k]) begin
          errors++;
          $display("FAIL random amt=%0d cycle %0d: got %h expected %h", amt, k + 1, act_trace_q[k], exp_trace_q[k]);
        end
      end
      checks++;
      if (coin_count !== 8'(exp_count)) begin
        errors++;
        $display("FAIL random_count amt=%0d: got %0d expected %0d", amt, coin_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int amt;
    model_payout(8);
    run_cycles(8, 2, 0, 0, 0);
    checks++;
    if ({coin5_out, coin2_out, coin1_out} !== exp_trace_q[2][12:10]) begin
      errors++;
      $display("FAIL rst_mid_pre: got coins=%b expected %b", {coin5_out, coin2_out, coin1_out}, exp_trace_q[2][12:10]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({coin5_out, coin2_out, coin1_out, busy, remaining, coin_count} !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid_async: got coins=%b busy=%b rem=%0d cnt=%0d expected all zero",
               {coin5_out, coin2_out, coin1_out}, busy, remaining, coin_count);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    amt = $urandom_range(1, 30);
    model_payout(amt);
    run_cycles(amt, exp_trace_q.size(), 0, 0, 0);
    for (int k = 0; k < exp_trace_q.size(); k++) begin
      checks++;
      if (act_trace_q[k] !== exp_trace_q[k]) begin
        errors++;
        $display("FAIL rst_mid_fresh amt=%0d cycle %0d: got %h expected %h", amt, k + 1, act_trace_q[k], exp_trace_q[k]);
      end
    end
  endtask

`ifdef TUBE_LIMIT_EN
  task automatic test_tube();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      model_payout(10);
      run_cycles(10, exp_trace_q.size(), 0, 0, 0);
      for (int k = 0; k < exp_trace_q.size(); k++) begin
        checks++;
        if (act_trace_q[k] !== exp_trace_q[k]) begin
          errors++;
          $display("FAIL tube pass %0d cycle %0d: got %h expected %h", pass, k + 1, act_trace_q[k], exp_trace_q[k]);
        end
      end
      checks++;
      if (tube5_empty !== (m_t5 == 0) || tube2_empty !== (m_t2 == 0)) begin
        errors++;
        $display("FAIL tube_empty pass %0d: got t5e=%b t2e=%b expected %b %b", pass, tube5_empty, tube2_empty, m_t5 == 0, m_t2 == 0);
      end
    end
    tube_refill = 1'b1;
    @(negedge clk);
    tube_refill = 1'b0;
    model_reset();
    checks++;
    if (tube5_empty !== 1'b0 || tube2_empty !== 1'b0) begin
      errors++;
      $display("FAIL tube_refill: got t5e=%b t2e=%b expected 0 0", tube5_empty, tube2_empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_payout_8();
    test_zero_amount();
    test_abort();
    test_ignore_start();
    test_start_abort_idle();
    test_random();
    test_reset_mid_pulse();
`ifdef TUBE_LIMIT_EN
    test_tube();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of fsm_controller. Consumes the change amount (change_due) and a start pulse when a vend completes, then pays out change one physical coin at a time.
- Coin selection is greedy: 5, then 2, then 1.
- Each coin is a timed solenoid pulse, followed by a mechanical gap.
- Reports busy/done status, remaining amount and coins paid to led_feedback/display_driver.

Parameters:
PULSE_CYCLES, 4, cycles each coin solenoid output is held high (>=1)
GAP_CYCLES, 8, idle cycles after each pulse before next selection (>=1)
CNT_W, 16, width of internal pulse/gap timer

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  single-cycle request to dispense amount
amount  input  8  change to pay, unsigned; sampled when start accepted
abort  input  1  synchronous cancel of a payout in progress
busy  output  1  high from cycle after accepted start until DONE exits
done  output  1  one-cycle pulse, payout complete
aborted  output  1  one-cycle pulse, payout cancelled
coin5_out  output  1  solenoid drive, value-5 coin
coin2_out  output  1  solenoid drive, value-2 coin
coin1_out  output  1  solenoid drive, value-1 coin
remaining  output  8  amount still owed
coin_count  output  8  coins paid since last accepted start, saturates at 255

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; remaining=0; coin_count=0; timer=0.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - start=1 with amount!=0: latch remaining=amount, clear coin_count, go to SELECT. busy=1 from the next cycle.
  - start=1 with amount==0: go to DONE directly. No coins are paid.
- start outside IDLE is ignored; the new amount is not latched.
- SELECT (1 cycle): pick 5 if remaining>=5, else 2 if >=2, else 1. Load timer=PULSE_CYCLES-1. Go to PULSE.
- PULSE:
  - Only the selected coinN_out is high, for exactly PULSE_CYCLES cycles.
  - On the last pulse cycle: remaining -= coin value, coin_count += 1 (saturating), load timer=GAP_CYCLES-1, go to GAP.
- GAP: all coin outputs low for GAP_CYCLES cycles. Then go to DONE if remaining==0, else SELECT.
- DONE (1 cycle): done=1. busy drops the following cycle. Return to IDLE.
- Coin outputs are one-hot or all-zero in every cycle. No combinational path from inputs to coin outputs (registered).
- Per-coin period is 1+PULSE_CYCLES+GAP_CYCLES cycles. Latency from start to done = 1 + N*(1+PULSE_CYCLES+GAP_CYCLES) + 1 cycles, where N = coins paid.
- abort in any non-IDLE state:
  - Next cycle: coin outputs low, aborted=1 for one cycle, state IDLE, busy low.
  - remaining holds the unpaid value until the next accepted start.
  - Decrement for a truncated pulse is not applied.
- abort and start in the same cycle in IDLE: start wins; abort is ignored in IDLE.
- Reset mid-payout: immediate return to reset values. A solenoid drive is cut asynchronously.

Optional Feature:
Macro TUBE_LIMIT_EN.
- Defined: adds parameters TUBE5_INIT (default 10) and TUBE2_INIT (default 10).
  - Adds input tube_refill (1), which reloads both tube counters to their INIT values; ignored while busy.
  - Adds outputs tube5_empty and tube2_empty (1 each).
  - Each dispensed 5/2 coin decrements its 8-bit tube counter.
  - SELECT skips an empty denomination (5 -> 2 -> 1). The 1-coin supply is unlimited.
  - Reset loads the INIT values.
- Undefined: all tubes are treated as infinite. The extra ports and parameters do not exist.

Decomposition:
- Shared package vm_change_pkg:
  - state encoding constants
  - coin value constants (5, 2, 1)
  - coin-select encoding (NONE, C5, C2, C1)
- Sub-module change_timer: loadable CNT_W-bit down-counter with a zero flag, used for both the pulse and gap intervals. The FSM and datapath stay in change_dispenser.

Test Plan:
- PULSE=2, GAP=3, start with amount=8 -> coin5_out, coin2_out, coin1_out each high 2 cycles, in that order.
  - remaining reads 8 -> 3 -> 1 -> 0.
  - coin_count=3.
  - done pulses exactly 20 cycles after start.
- start with amount=0 -> done 1 cycle later, busy never 1, no coin outputs.
- start amount=12, abort during 2nd coin pulse -> coin2_out drops next cycle, aborted=1, remaining=7, coin_count=1, state IDLE.
- start amount=4, then start amount=9 while busy -> second ignored; payout 2, 2; coin_count=2.
- rst pulled low mid-PULSE -> coin output, busy and remaining go to 0 asynchronously. A fresh start after reset release works normally.
- TUBE_LIMIT_EN, TUBE5_INIT=1: two start amount=10 payouts.
  - First payout: 5, 2, 2, 1; tube5_empty=1 afterwards.
  - Second payout: 2, 2, 2, 2, 2.
  - tube_refill restores tube5_empty=0.
